// File: rtl/ft232h_sync_bridge.sv
// rtl/ft232h_sync_bridge.sv - FT232H 245-sync FIFO bridge with round-robin burst arbitration
module ft232h_sync_bridge #(
    parameter int DATA_W      = 8,
    parameter int BURST_MAX   = 64,
    parameter bit PRIORITY_RX = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk60,
    input  logic              rst,
    input  logic              RXFn,
    input  logic              TXEn,
    input  logic [DATA_W-1:0] adbus_in,
    output logic [DATA_W-1:0] adbus_out,
    output logic              adbus_oe,
    output logic              OEn,
    output logic              RDn,
    output logic              WRn,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_wrreq,
    input  logic              rx_full,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_rdreq,
    input  logic              tx_empty,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  tx_count
);

    typedef enum logic [2:0] {
        IDLE,
        RX_OE,
        RX_READ,
        TX_WRITE,
        TURN
    } state_t;

    localparam logic [15:0] BMAX = 16'(BURST_MAX);

    state_t      state, state_nxt;
    logic [15:0] burst, burst_nxt, burst_inc;
    logic        last_rx, last_rx_nxt;
    logic        dir_rx, dir_rx_nxt;
    logic        rx_pend, tx_pend;

    always_ff @(posedge clk60) begin
        if (rst) begin
            state    <= IDLE;
            burst    <= 16'd0;
            last_rx  <= !PRIORITY_RX;
            dir_rx   <= PRIORITY_RX;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            state   <= state_nxt;
            burst   <= burst_nxt;
            last_rx <= last_rx_nxt;
            dir_rx  <= dir_rx_nxt;
            if (rx_wrreq)
                rx_count <= rx_count + CNT_W'(1);
            if (tx_rdreq)
                tx_count <= tx_count + CNT_W'(1);
        end
    end

    always_comb begin
        rx_pend     = !RXFn && !rx_full;
        tx_pend     = !TXEn && !tx_empty;
        state_nxt   = state;
        burst_nxt   = burst;
        last_rx_nxt = last_rx;
        dir_rx_nxt  = dir_rx;
        OEn         = 1'b1;
        RDn         = 1'b1;
        WRn         = 1'b1;
        adbus_oe    = 1'b0;
        rx_wrreq    = 1'b0;
        tx_rdreq    = 1'b0;
        adbus_out   = tx_data;
        rx_data     = adbus_in;
        // Saturates so an uncontended stream can run indefinitely.
        burst_inc   = (burst < BMAX) ? burst + 16'd1 : burst;

        case (state)
            IDLE: begin
                if (rx_pend && (!tx_pend || !last_rx)) begin
                    state_nxt  = RX_OE;
                    burst_nxt  = 16'd0;
                    dir_rx_nxt = 1'b1;
                end else if (tx_pend) begin
                    state_nxt  = TX_WRITE;
                    burst_nxt  = 16'd0;
                    dir_rx_nxt = 1'b0;
                end
            end
            RX_OE: begin
                OEn       = 1'b0;
                state_nxt = RX_READ;
            end
            RX_READ: begin
                OEn      = 1'b0;
                RDn      = rx_full;
                rx_wrreq = !rx_full && !RXFn;
                if (rx_wrreq)
                    burst_nxt = burst_inc;
                if (RXFn || rx_full || (burst_nxt == BMAX && tx_pend))
                    state_nxt = TURN;
            end
            TX_WRITE: begin
                adbus_oe = 1'b1;
                WRn      = tx_empty;
                tx_rdreq = !tx_empty && !TXEn;
                if (tx_rdreq)
                    burst_nxt = burst_inc;
                if (TXEn || tx_empty || (burst_nxt == BMAX && rx_pend))
                    state_nxt = TURN;
            end
            TURN: begin
                last_rx_nxt = dir_rx;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ft232h_sync_bridge.sv
// tb/tb_ft232h_sync_bridge.sv - directed self-checking bench for ft232h_sync_bridge
module tb_ft232h_sync_bridge;

    logic clk60 = 1'b0;
    always #5 clk60 = ~clk60;

    logic       rst, RXFn, TXEn, rx_full, tx_empty;
    logic [7:0] adbus_in, tx_data;
    logic [7:0] adbus_out, rx_data;
    logic       adbus_oe, OEn, RDn, WRn, rx_wrreq, tx_rdreq;
    logic [15:0] rx_count, tx_count;

    logic [7:0] b_adbus_out, b_rx_data;
    logic       b_adbus_oe, b_OEn, b_RDn, b_WRn, b_rx_wrreq, b_tx_rdreq;
    logic [3:0] b_rx_count, b_tx_count;

    ft232h_sync_bridge #(.DATA_W(8), .BURST_MAX(4), .PRIORITY_RX(1'b1), .CNT_W(16)) dut_a (
        .clk60(clk60), .rst(rst), .RXFn(RXFn), .TXEn(TXEn), .adbus_in(adbus_in),
        .adbus_out(adbus_out), .adbus_oe(adbus_oe), .OEn(OEn), .RDn(RDn), .WRn(WRn),
        .rx_data(rx_data), .rx_wrreq(rx_wrreq), .rx_full(rx_full), .tx_data(tx_data),
        .tx_rdreq(tx_rdreq), .tx_empty(tx_empty), .rx_count(rx_count), .tx_count(tx_count)
    );

    ft232h_sync_bridge #(.DATA_W(8), .BURST_MAX(64), .PRIORITY_RX(1'b1), .CNT_W(4)) dut_b (
        .clk60(clk60), .rst(rst), .RXFn(RXFn), .TXEn(TXEn), .adbus_in(adbus_in),
        .adbus_out(b_adbus_out), .adbus_oe(b_adbus_oe), .OEn(b_OEn), .RDn(b_RDn), .WRn(b_WRn),
        .rx_data(b_rx_data), .rx_wrreq(b_rx_wrreq), .rx_full(rx_full), .tx_data(tx_data),
        .tx_rdreq(b_tx_rdreq), .tx_empty(tx_empty), .rx_count(b_rx_count), .tx_count(b_tx_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] host_rx [0:63];
    logic [7:0] txq     [0:63];
    logic [7:0] got_rx  [0:63];
    logic [7:0] got_tx  [0:63];
    int  runs   [0:63];
    bit  run_rx [0:63];
    int  hrx_n, hrx_i, tq_n, tq_i, got_n, gtx_n, run_n, cur_run, quiet;
    int  turn_err, overlap_err, strobe_err;
    bit  cur_dir, rxf_hold, txe_hold;
    logic s_oen, s_rdn, s_wrn, s_oe, s_wrreq;

    task automatic drive();
        RXFn     = rxf_hold || (hrx_i >= hrx_n);
        adbus_in = (hrx_i < hrx_n) ? host_rx[hrx_i] : 8'h00;
        TXEn     = txe_hold;
        tx_empty = (tq_i >= tq_n);
        tx_data  = (tq_i < tq_n) ? txq[tq_i] : 8'h00;
    endtask

    // One clk60 cycle: drive the fake FT232H/FIFOs, sample mid-cycle, advance models after the edge.
    task automatic tick();
        bit rx_x, tx_x;
        drive();
        @(negedge clk60);
        s_oen = OEn; s_rdn = RDn; s_wrn = WRn; s_oe = adbus_oe; s_wrreq = rx_wrreq;
        rx_x = (RDn === 1'b0) && (RXFn === 1'b0);
        tx_x = (tx_rdreq === 1'b1);
        if (!OEn && adbus_oe) overlap_err++;
        if (rx_x && tx_x) overlap_err++;
        if (rx_x !== (rx_wrreq === 1'b1)) strobe_err++;
        if (rx_wrreq === 1'b1) begin
            if (got_n < 64) got_rx[got_n] = rx_data;
            got_n++;
        end
        if (tx_x) begin
            if (WRn !== 1'b0 || adbus_oe !== 1'b1 || TXEn) strobe_err++;
            if (gtx_n < 64) got_tx[gtx_n] = adbus_out;
            gtx_n++;
        end
        if (rx_x || tx_x) begin
            if (cur_run > 0 && cur_dir == rx_x) begin
                cur_run++;
            end else begin
                if (cur_run > 0) begin
                    if (run_n < 64) begin runs[run_n] = cur_run; run_rx[run_n] = cur_dir; end
                    run_n++;
                    if (quiet < 2) turn_err++;
                end
                cur_dir = rx_x;
                cur_run = 1;
            end
            quiet = 0;
        end else if (OEn && !adbus_oe) begin
            quiet++;
        end
        @(posedge clk60);
        #1;
        if (rx_x) hrx_i++;
        if (tx_x) tq_i++;
    endtask

    task automatic finish_runs();
        if (cur_run > 0) begin
            if (run_n < 64) begin runs[run_n] = cur_run; run_rx[run_n] = cur_dir; end
            run_n++;
            cur_run = 0;
        end
    endtask

    task automatic clear_models();
        hrx_n = 0; hrx_i = 0; tq_n = 0; tq_i = 0; got_n = 0; gtx_n = 0;
        run_n = 0; cur_run = 0; quiet = 0; cur_dir = 1'b0;
        turn_err = 0; overlap_err = 0; strobe_err = 0;
        rxf_hold = 1'b0; txe_hold = 1'b1; rx_full = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_models();
        host_rx[0] = 8'h55; host_rx[1] = 8'h66; hrx_n = 2;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (s_oen !== 1'b1 || s_rdn !== 1'b1 || s_wrn !== 1'b1 || s_oe !== 1'b0 || s_wrreq !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: OEn=%b RDn=%b WRn=%b oe=%b wrreq=%b, required 1 1 1 0 0",
                         c, s_oen, s_rdn, s_wrn, s_oe, s_wrreq);
            end
            checks++;
            if (rx_count !== 16'd0 || tx_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_counts cycle %0d: rx_count=%0d tx_count=%0d, required 0 0", c, rx_count, tx_count);
            end
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (s_oen !== 1'b0 || s_rdn !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_oe: OEn=%b RDn=%b, required 0 1", s_oen, s_rdn);
        end
        tick();
        checks++;
        if (s_oen !== 1'b0 || s_rdn !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rd: OEn=%b RDn=%b, required 0 0", s_oen, s_rdn);
        end
    endtask

    task automatic test_rx_stream();
        do_reset();
        for (int i = 0; i < 10; i++) host_rx[i] = 8'(i);
        hrx_n = 10;
        for (int c = 0; c < 40 && got_n < 10; c++) tick();
        repeat (4) tick();
        checks++;
        if (got_n !== 10) begin
            errors++;
            $display("FAIL rx_stream_len: got %0d words, required 10", got_n);
        end
        for (int i = 0; i < 10 && i < got_n; i++) begin
            checks++;
            if (got_rx[i] !== 8'(i)) begin
                errors++;
                $display("FAIL rx_stream_data[%0d]: got 0x%02h, required 0x%02h", i, got_rx[i], 8'(i));
            end
        end
        checks++;
        if (rx_count !== 16'd10 || tx_count !== 16'd0) begin
            errors++;
            $display("FAIL rx_stream_count: rx_count=%0d tx_count=%0d, required 10 0", rx_count, tx_count);
        end
        checks++;
        if (s_oen !== 1'b1 || s_oe !== 1'b0 || s_rdn !== 1'b1 || strobe_err !== 0) begin
            errors++;
            $display("FAIL rx_stream_idle: OEn=%b oe=%b RDn=%b strobe_err=%0d, required 1 0 1 0",
                     s_oen, s_oe, s_rdn, strobe_err);
        end
    endtask

    task automatic test_rx_backpressure();
        int bp_err;
        do_reset();
        for (int i = 0; i < 10; i++) host_rx[i] = 8'h10 + 8'(i);
        hrx_n = 10;
        for (int c = 0; c < 30 && hrx_i < 5; c++) tick();
        rx_full = 1'b1;
        bp_err = 0;
        repeat (5) begin
            tick();
            if (s_rdn !== 1'b1 || s_wrreq !== 1'b0) bp_err++;
        end
        rx_full = 1'b0;
        checks++;
        if (bp_err !== 0 || hrx_i !== 5) begin
            errors++;
            $display("FAIL rx_full_hold: bad cycles=%0d host index=%0d, required 0 5", bp_err, hrx_i);
        end
        for (int c = 0; c < 40 && got_n < 10; c++) tick();
        repeat (3) tick();
        checks++;
        if (got_n !== 10 || rx_count !== 16'd10) begin
            errors++;
            $display("FAIL rx_full_len: got %0d words rx_count=%0d, required 10 10", got_n, rx_count);
        end
        for (int i = 0; i < 10 && i < got_n; i++) begin
            checks++;
            if (got_rx[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL rx_full_data[%0d]: got 0x%02h, required 0x%02h", i, got_rx[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_tx_stream();
        int pre;
        do_reset();
        for (int i = 0; i < 8; i++) txq[i] = 8'hA0 + 8'(i);
        tq_n = 8;
        txe_hold = 1'b0;
        for (int c = 0; c < 30 && tq_i < 3; c++) tick();
        txe_hold = 1'b1;
        pre = gtx_n;
        repeat (3) tick();
        checks++;
        if (gtx_n !== pre) begin
            errors++;
            $display("FAIL tx_pause: %0d words during pause, required 0", gtx_n - pre);
        end
        txe_hold = 1'b0;
        for (int c = 0; c < 40 && gtx_n < 8; c++) tick();
        repeat (3) tick();
        checks++;
        if (gtx_n !== 8 || tx_count !== 16'd8 || rx_count !== 16'd0) begin
            errors++;
            $display("FAIL tx_stream_count: words=%0d tx_count=%0d rx_count=%0d, required 8 8 0",
                     gtx_n, tx_count, rx_count);
        end
        for (int i = 0; i < 8 && i < gtx_n; i++) begin
            checks++;
            if (got_tx[i] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL tx_stream_data[%0d]: got 0x%02h, required 0x%02h", i, got_tx[i], 8'hA0 + 8'(i));
            end
        end
        checks++;
        if (strobe_err !== 0 || s_oe !== 1'b0 || s_wrn !== 1'b1) begin
            errors++;
            $display("FAIL tx_stream_strobes: strobe_err=%0d oe=%b WRn=%b, required 0 0 1", strobe_err, s_oe, s_wrn);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            host_rx[i] = 8'h40 + 8'(i);
            txq[i]     = 8'hC0 + 8'(i);
        end
        hrx_n = 24;
        tq_n  = 24;
        txe_hold = 1'b0;
        for (int c = 0; c < 250 && (got_n < 24 || gtx_n < 24); c++) tick();
        repeat (3) tick();
        finish_runs();
        checks++;
        if (run_n !== 12) begin
            errors++;
            $display("FAIL arb_bursts: %0d bursts, required 12", run_n);
        end
        for (int i = 0; i < 12 && i < run_n; i++) begin
            checks++;
            if (runs[i] !== 4 || run_rx[i] !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL arb_burst[%0d]: len=%0d rx=%0d, required len 4 rx %0d", i, runs[i], run_rx[i], (i % 2 == 0));
            end
        end
        checks++;
        if (overlap_err !== 0 || turn_err !== 0 || strobe_err !== 0) begin
            errors++;
            $display("FAIL arb_turnaround: overlap=%0d short_turn=%0d strobe=%0d, required 0 0 0",
                     overlap_err, turn_err, strobe_err);
        end
        checks++;
        if (rx_count !== 16'd24 || tx_count !== 16'd24) begin
            errors++;
            $display("FAIL arb_counts: rx_count=%0d tx_count=%0d, required 24 24", rx_count, tx_count);
        end
        for (int i = 0; i < 24 && i < got_n && i < gtx_n; i++) begin
            checks++;
            if (got_rx[i] !== 8'h40 + 8'(i) || got_tx[i] !== 8'hC0 + 8'(i)) begin
                errors++;
                $display("FAIL arb_data[%0d]: rx 0x%02h tx 0x%02h, required 0x%02h 0x%02h",
                         i, got_rx[i], got_tx[i], 8'h40 + 8'(i), 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) host_rx[i] = 8'h80 + 8'(i);
        hrx_n = 17;
        for (int c = 0; c < 60 && got_n < 17; c++) tick();
        repeat (3) tick();
        checks++;
        if (b_rx_count !== 4'd1 || b_tx_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_count: rx_count=%0d tx_count=%0d, required 1 0", b_rx_count, b_tx_count);
        end
        checks++;
        if (rx_count !== 16'd17) begin
            errors++;
            $display("FAIL wrap_wide_count: rx_count=%0d, required 17", rx_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) host_rx[i] = 8'(i);
        hrx_n = 10;
        for (int c = 0; c < 30 && hrx_i < 3; c++) tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (s_oen !== 1'b1 || s_rdn !== 1'b1 || s_wrn !== 1'b1 || s_oe !== 1'b0 || s_wrreq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobes: OEn=%b RDn=%b WRn=%b oe=%b wrreq=%b, required 1 1 1 0 0",
                     s_oen, s_rdn, s_wrn, s_oe, s_wrreq);
        end
        checks++;
        if (rx_count !== 16'd0 || tx_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_counts: rx_count=%0d tx_count=%0d, required 0 0", rx_count, tx_count);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_models();
        drive();
        @(posedge clk60);
        #1;
        test_reset();
        test_rx_stream();
        test_rx_backpressure();
        test_tx_stream();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft232h_sync_bridge.md
Name: ft232h_sync_bridge

Overview:
Parametrised successor to the FT232H synchronous-FIFO interface. Sits in the clk60 domain between the FT232H 245-sync bus and two on-chip FIFOs: host-to-FPGA (rx) and FPGA-to-host (tx). Generalised over bus width, burst limit and arbitration start direction. Adds behaviour the previous interface lacks: round-robin direction arbitration with a bounded burst length, a guaranteed bus turnaround cycle, and transfer counters.

Parameters:
DATA_W, 8, bus and FIFO data width (8 for FT232H, 16 for wide-bus parts)
BURST_MAX, 64, max consecutive transfers in one direction while the other direction is pending; legal range 1..65535
PRIORITY_RX, 1, direction served first after reset when both are pending (1 = rx)
CNT_W, 16, width of transfer counters

Ports:
clk60  in  1  60 MHz FT232H CLKOUT; sole clock
rst  in  1  synchronous, active-high reset
RXFn  in  1  FT232H: data available to read (low)
TXEn  in  1  FT232H: space available to write (low)
adbus_in  in  DATA_W  FT232H data bus input
adbus_out  out  DATA_W  data driven to FT232H
adbus_oe  out  1  tristate enable for adbus_out
OEn  out  1  FT232H output enable (low)
RDn  out  1  FT232H read strobe (low)
WRn  out  1  FT232H write strobe (low)
rx_data  out  DATA_W  word to rx FIFO
rx_wrreq  out  1  rx FIFO write strobe
rx_full  in  1  rx FIFO full
tx_data  in  DATA_W  head of show-ahead tx FIFO, valid when !tx_empty
tx_rdreq  out  1  tx FIFO pop
tx_empty  in  1  tx FIFO empty
rx_count  out  CNT_W  words received, wraps modulo 2^CNT_W
tx_count  out  CNT_W  words sent, wraps modulo 2^CNT_W

Behaviour:
- Single clock clk60, synchronous active-high rst. During and after rst: state IDLE, OEn=RDn=WRn=1, adbus_oe=0, rx_wrreq=0, tx_rdreq=0, counters 0, burst counter 0, last-served = opposite of PRIORITY_RX.
- Definitions: rx_pend = !RXFn & !rx_full; tx_pend = !TXEn & !tx_empty.
- States: IDLE, RX_OE, RX_READ, TX_WRITE, TURN.
- IDLE: if exactly one of rx_pend/tx_pend is set, go to RX_OE or TX_WRITE. If both are set, serve the direction not served last. If neither, stay. Burst counter clears on entry to RX_OE/TX_WRITE.
- RX_OE: OEn=0 for one cycle, then RX_READ. No data is captured here.
- RX_READ: OEn=0; RDn = rx_full (combinational).
  - Transfer on a clk60 edge where RDn=0 & RXFn=0: rx_data<=adbus_in; rx_wrreq=1 for that cycle; rx_count++; burst++.
  - Exit to TURN when RXFn=1, when rx_full=1, or when burst reaches BURST_MAX and tx_pend=1.
  - Burst at BURST_MAX with tx idle: keep reading; counter holds at BURST_MAX.
- TX_WRITE: adbus_oe=1; adbus_out=tx_data; WRn = tx_empty (combinational); tx_rdreq = !WRn & !TXEn.
  - Each tx_rdreq cycle increments tx_count and burst.
  - Exit to TURN when TXEn=1, when tx_empty=1, or when burst reaches BURST_MAX and rx_pend=1.
- TURN: one cycle with OEn=1, adbus_oe=0, RDn=WRn=1; record last-served; then IDLE.
- OEn=0 and adbus_oe=1 are never asserted in the same cycle. Every direction change passes through TURN and IDLE.
- Latency: host data to rx_wrreq is 0 cycles in RX_READ (registered data, strobe in capture cycle). First RX word arrives no earlier than 2 cycles after leaving IDLE.
- RXFn rising mid-burst: no capture on that edge; exit as above.
- rst asserted mid-transfer: all strobes deassert at the next edge; no partial counts.

Test Plan:
- Reset: hold rst 3 cycles with RXFn=0 -> OEn/RDn/WRn=1, adbus_oe=0, counters 0 throughout; after release, OEn low next cycle, RDn low one cycle later.
- RX stream: fake FT232H delivers 10 bytes 0x00..0x09, tx_empty=1 -> rx FIFO receives exactly 0x00..0x09 in order; rx_count=10; returns to IDLE via one TURN cycle.
- rx_full backpressure: raise rx_full after byte 4 for 5 cycles -> RDn high same cycle; no lost or duplicated bytes; rx_count ends at 10.
- TX stream: tx FIFO holds 0xA0..0xA7, TXEn=0 -> 8 WRn-low cycles carrying 0xA0..0xA7; tx_count=8. Toggling TXEn high for 3 cycles mid-stream pauses the transfer with no loss.
- Burst arbitration with BURST_MAX=4: both directions continuously pending -> alternating bursts of 4 rx / 4 tx, each separated by TURN; adbus_oe and !OEn never overlap.
- Counter wrap with CNT_W=4: 17 rx words -> rx_count=1.
